// File: rtl/autosa_cmac_csb_reg_master.sv
// CSB register initiator for CMAC_A: owns STATUS/POINTER and per-group op_en, fronts two dual-group slaves.
// Optional define AUTOSA_CMAC_REG_WR_PROTECT_EN blocks dual-space writes to a group whose op_en is set.
module autosa_cmac_csb_reg_master #(
    parameter int AW = 22,
    parameter int DW = 32
) (
    input  logic          autosa_core_clk,
    input  logic          autosa_core_rstn,
    input  logic          csb_req_pvld,
    output logic          csb_req_prdy,
    input  logic [AW-1:0] csb_req_addr,
    input  logic [DW-1:0] csb_req_wdat,
    input  logic          csb_req_write,
    input  logic          csb_req_nposted,
    output logic          csb_resp_valid,
    output logic [33:0]   csb_resp_pd,
    output logic [11:0]   reg_offset,
    output logic [DW-1:0] reg_wr_data,
    output logic          d0_reg_wr_en,
    output logic          d1_reg_wr_en,
    input  logic [DW-1:0] d0_reg_rd_data,
    input  logic [DW-1:0] d1_reg_rd_data,
    input  logic          d0_op_en_trigger,
    input  logic          d1_op_en_trigger,
    output logic          d0_op_en,
    output logic          d1_op_en,
    input  logic          dp2reg_done,
    output logic          producer,
    output logic          consumer
);

    localparam logic [11:0] STATUS_OFS  = 12'h000;
    localparam logic [11:0] POINTER_OFS = 12'h004;
    localparam logic [11:0] DUAL_BASE   = 12'h008;

    logic          prdy_r;
    logic          req_vld_r;
    logic [9:0]    req_addr_r;
    logic [DW-1:0] req_wdat_r;
    logic          req_write_r;
    logic          req_nposted_r;
    logic          producer_r;
    logic          consumer_r;
    logic          d0_op_en_r;
    logic          d1_op_en_r;
    logic          resp_valid_r;
    logic [33:0]   resp_pd_r;

    logic          accept_s;
    logic [11:0]   offset_s;
    logic [DW-1:0] wr_data_s;
    logic          wr_s;
    logic          dual_s;
    logic          blocked_s;
    logic          dual_wr_s;
    logic          done_hit_s;
    logic [DW-1:0] rdata_s;
    logic          d0_op_en_next_s;
    logic          d1_op_en_next_s;
    logic          producer_next_s;
    logic          consumer_next_s;
    logic          resp_valid_next_s;
    logic [33:0]   resp_pd_next_s;
    logic          addr_hi_unused_s;

    assign addr_hi_unused_s = ^csb_req_addr[AW-1:10];

    assign accept_s  = csb_req_pvld & prdy_r;
    assign offset_s  = req_vld_r ? {req_addr_r, 2'b00} : 12'h000;
    assign wr_data_s = req_vld_r ? req_wdat_r : {DW{1'b0}};
    assign wr_s      = req_vld_r & req_write_r;
    assign dual_s    = req_vld_r & (offset_s >= DUAL_BASE);

`ifdef AUTOSA_CMAC_REG_WR_PROTECT_EN
    // OP_ENABLE itself stays writable so a running group can still be re-armed or stopped
    assign blocked_s = wr_s & dual_s & (producer_r ? d1_op_en_r : d0_op_en_r) & (offset_s != DUAL_BASE);
`else
    assign blocked_s = 1'b0;
`endif

    assign dual_wr_s  = wr_s & dual_s & ~blocked_s;
    assign done_hit_s = dp2reg_done & (consumer_r ? d1_op_en_r : d0_op_en_r);

    // Read-data mux over single registers and the producer group's slave
    always_comb begin
        rdata_s = {DW{1'b0}};
        if (offset_s == STATUS_OFS) begin
            rdata_s[0]  = d0_op_en_r;
            rdata_s[16] = d1_op_en_r;
        end else if (offset_s == POINTER_OFS) begin
            rdata_s[0]  = producer_r;
            rdata_s[16] = consumer_r;
        end else if (dual_s) begin
            rdata_s = producer_r ? d1_reg_rd_data : d0_reg_rd_data;
        end else begin
            rdata_s = {DW{1'b0}};
        end
    end

    // Next-state for pointers and op_en; a trigger beats a done on the same group
    always_comb begin
        producer_next_s = producer_r;
        consumer_next_s = consumer_r;
        d0_op_en_next_s = d0_op_en_r;
        d1_op_en_next_s = d1_op_en_r;
        if (wr_s && (offset_s == POINTER_OFS)) begin
            producer_next_s = wr_data_s[0];
        end else begin
            producer_next_s = producer_r;
        end
        if (d0_op_en_trigger) begin
            d0_op_en_next_s = wr_data_s[0];
        end else if (done_hit_s && !consumer_r) begin
            d0_op_en_next_s = 1'b0;
        end else begin
            d0_op_en_next_s = d0_op_en_r;
        end
        if (d1_op_en_trigger) begin
            d1_op_en_next_s = wr_data_s[0];
        end else if (done_hit_s && consumer_r) begin
            d1_op_en_next_s = 1'b0;
        end else begin
            d1_op_en_next_s = d1_op_en_r;
        end
        if (done_hit_s) begin
            consumer_next_s = ~consumer_r;
        end else begin
            consumer_next_s = consumer_r;
        end
    end

    // Response formation: reads always answer, writes only when non-posted
    always_comb begin
        resp_valid_next_s = req_vld_r & (~req_write_r | req_nposted_r);
        resp_pd_next_s    = 34'h0_0000_0000;
        if (!resp_valid_next_s) begin
            resp_pd_next_s = 34'h0_0000_0000;
        end else if (req_write_r) begin
            resp_pd_next_s = {1'b1, blocked_s, {DW{1'b0}}};
        end else begin
            resp_pd_next_s = {1'b0, 1'b0, rdata_s};
        end
    end

    // Request stage, control state and response registers
    always_ff @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            prdy_r        <= 1'b0;
            req_vld_r     <= 1'b0;
            req_addr_r    <= 10'h000;
            req_wdat_r    <= {DW{1'b0}};
            req_write_r   <= 1'b0;
            req_nposted_r <= 1'b0;
            producer_r    <= 1'b0;
            consumer_r    <= 1'b0;
            d0_op_en_r    <= 1'b0;
            d1_op_en_r    <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_pd_r     <= 34'h0_0000_0000;
        end else begin
            prdy_r    <= 1'b1;
            req_vld_r <= accept_s;
            if (accept_s) begin
                req_addr_r    <= csb_req_addr[9:0];
                req_wdat_r    <= csb_req_wdat;
                req_write_r   <= csb_req_write;
                req_nposted_r <= csb_req_nposted;
            end
            producer_r   <= producer_next_s;
            consumer_r   <= consumer_next_s;
            d0_op_en_r   <= d0_op_en_next_s;
            d1_op_en_r   <= d1_op_en_next_s;
            resp_valid_r <= resp_valid_next_s;
            resp_pd_r    <= resp_pd_next_s;
        end
    end

    assign csb_req_prdy   = prdy_r;
    assign csb_resp_valid = resp_valid_r;
    assign csb_resp_pd    = resp_pd_r;
    assign reg_offset     = offset_s;
    assign reg_wr_data    = wr_data_s;
    assign d0_reg_wr_en   = dual_wr_s & ~producer_r;
    assign d1_reg_wr_en   = dual_wr_s & producer_r;
    assign d0_op_en       = d0_op_en_r;
    assign d1_op_en       = d1_op_en_r;
    assign producer       = producer_r;
    assign consumer       = consumer_r;

endmodule

// File: tb/tb_autosa_cmac_csb_reg_master.sv
// Randomized bench for autosa_cmac_csb_reg_master with behavioural register-space model and simple slave models.
module tb_autosa_cmac_csb_reg_master;

    logic        autosa_core_clk = 1'b0;
    logic        autosa_core_rstn = 1'b0;
    logic        csb_req_pvld = 1'b0;
    logic        csb_req_prdy;
    logic [21:0] csb_req_addr = 22'h0;
    logic [31:0] csb_req_wdat = 32'h0;
    logic        csb_req_write = 1'b0;
    logic        csb_req_nposted = 1'b0;
    logic        csb_resp_valid;
    logic [33:0] csb_resp_pd;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        d0_reg_wr_en, d1_reg_wr_en;
    logic [31:0] d0_reg_rd_data, d1_reg_rd_data;
    logic        d0_op_en_trigger, d1_op_en_trigger;
    logic        d0_op_en, d1_op_en;
    logic        dp2reg_done = 1'b0;
    logic        producer, consumer;

    int n_checks = 0;
    int n_errors = 0;

    always #5 autosa_core_clk = ~autosa_core_clk;

    autosa_cmac_csb_reg_master #(.AW(22), .DW(32)) dut (
        .autosa_core_clk  (autosa_core_clk),
        .autosa_core_rstn (autosa_core_rstn),
        .csb_req_pvld     (csb_req_pvld),
        .csb_req_prdy     (csb_req_prdy),
        .csb_req_addr     (csb_req_addr),
        .csb_req_wdat     (csb_req_wdat),
        .csb_req_write    (csb_req_write),
        .csb_req_nposted  (csb_req_nposted),
        .csb_resp_valid   (csb_resp_valid),
        .csb_resp_pd      (csb_resp_pd),
        .reg_offset       (reg_offset),
        .reg_wr_data      (reg_wr_data),
        .d0_reg_wr_en     (d0_reg_wr_en),
        .d1_reg_wr_en     (d1_reg_wr_en),
        .d0_reg_rd_data   (d0_reg_rd_data),
        .d1_reg_rd_data   (d1_reg_rd_data),
        .d0_op_en_trigger (d0_op_en_trigger),
        .d1_op_en_trigger (d1_op_en_trigger),
        .d0_op_en         (d0_op_en),
        .d1_op_en         (d1_op_en),
        .dp2reg_done      (dp2reg_done),
        .producer         (producer),
        .consumer         (consumer)
    );

    // Slave stand-ins: 16-word register files, OP_ENABLE at offset 0x008 raises the trigger
    logic [31:0] slv0 [16];
    logic [31:0] slv1 [16];
    assign d0_reg_rd_data   = slv0[reg_offset[5:2]];
    assign d1_reg_rd_data   = slv1[reg_offset[5:2]];
    assign d0_op_en_trigger = d0_reg_wr_en && (reg_offset == 12'h008);
    assign d1_op_en_trigger = d1_reg_wr_en && (reg_offset == 12'h008);

    always @(posedge autosa_core_clk or negedge autosa_core_rstn) begin
        if (!autosa_core_rstn) begin
            for (int i = 0; i < 16; i++) begin
                slv0[i] <= 32'h0;
                slv1[i] <= 32'h0;
            end
        end else begin
            if (d0_reg_wr_en) slv0[reg_offset[5:2]] <= reg_wr_data;
            if (d1_reg_wr_en) slv1[reg_offset[5:2]] <= reg_wr_data;
        end
    end

    // Reference model state
    bit          m_prod, m_cons;
    bit          m_op [2];
    logic [31:0] m_mem [2][16];
    bit          p_vld, p_write, p_np;
    logic [9:0]  p_addr;
    logic [31:0] p_wdat;
    bit          exp_rv;
    logic [33:0] exp_pd;

`ifdef AUTOSA_CMAC_REG_WR_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_prod = 1'b0; m_cons = 1'b0; m_op[0] = 1'b0; m_op[1] = 1'b0;
        for (int g = 0; g < 2; g++)
            for (int i = 0; i < 16; i++) m_mem[g][i] = 32'h0;
        p_vld = 1'b0; exp_rv = 1'b0; exp_pd = 34'h0;
    endtask

    function automatic bit is_blocked(input logic [11:0] off, input bit wr);
        return PROTECT && wr && (off >= 12'h008) && m_op[m_prod] && (off != 12'h008);
    endfunction

    // One clock edge of the abstract register space: execute pending request, apply done, accept new request
    task automatic model_step(input bit done);
        logic [11:0] off;
        logic [31:0] rd;
        bit          trig [2];
        bit          n_prod, n_cons, blk;
        bit          n_op [2];
        trig[0] = 1'b0; trig[1] = 1'b0;
        n_prod = m_prod; n_cons = m_cons; n_op[0] = m_op[0]; n_op[1] = m_op[1];
        exp_rv = 1'b0; exp_pd = 34'h0;
        if (p_vld) begin
            off = {p_addr, 2'b00};
            blk = is_blocked(off, p_write);
            if (p_write) begin
                if (off == 12'h004) n_prod = p_wdat[0];
                if (off >= 12'h008 && !blk) begin
                    m_mem[m_prod][p_addr[3:0]] = p_wdat;
                    if (off == 12'h008) begin
                        trig[m_prod] = 1'b1;
                        n_op[m_prod] = p_wdat[0];
                    end
                end
                if (p_np) begin
                    exp_rv = 1'b1;
                    exp_pd = {1'b1, blk, 32'h0};
                end
            end else begin
                if (off == 12'h000)      rd = {15'h0, m_op[1], 15'h0, m_op[0]};
                else if (off == 12'h004) rd = {15'h0, m_cons, 15'h0, m_prod};
                else                     rd = m_mem[m_prod][p_addr[3:0]];
                exp_rv = 1'b1;
                exp_pd = {2'b00, rd};
            end
        end
        if (done && m_op[m_cons]) begin
            if (!trig[m_cons]) n_op[m_cons] = 1'b0;
            n_cons = !m_cons;
        end
        m_prod = n_prod; m_cons = n_cons; m_op[0] = n_op[0]; m_op[1] = n_op[1];
        p_vld   = csb_req_pvld;
        p_addr  = csb_req_addr[9:0];
        p_wdat  = csb_req_wdat;
        p_write = csb_req_write;
        p_np    = csb_req_nposted;
    endtask

    task automatic check_idle_outputs(input string pfx);
        check_val({pfx, "_prdy"}, {63'h0, csb_req_prdy}, 64'h0);
        check_val({pfx, "_resp_valid"}, {63'h0, csb_resp_valid}, 64'h0);
        check_val({pfx, "_resp_pd"}, {30'h0, csb_resp_pd}, 64'h0);
        check_val({pfx, "_reg_offset"}, {52'h0, reg_offset}, 64'h0);
        check_val({pfx, "_reg_wr_data"}, {32'h0, reg_wr_data}, 64'h0);
        check_val({pfx, "_wr_en"}, {62'h0, d1_reg_wr_en, d0_reg_wr_en}, 64'h0);
        check_val({pfx, "_op_en"}, {62'h0, d1_op_en, d0_op_en}, 64'h0);
        check_val({pfx, "_prod_cons"}, {62'h0, consumer, producer}, 64'h0);
    endtask

    initial begin
        logic [11:0] e_off;
        bit          e_dual, e_blk, done_now;
        int          r;

        model_reset();
        repeat (3) @(negedge autosa_core_clk);
        check_idle_outputs("rst");
        autosa_core_rstn = 1'b1;
        @(negedge autosa_core_clk);
        check_val("prdy_after_release", {63'h0, csb_req_prdy}, 64'h1);
        done_now = 1'b0;

        for (int c = 0; c < 4000; c++) begin
            // Registered outputs produced by the previous edge
            check_val("resp_valid", {63'h0, csb_resp_valid}, {63'h0, exp_rv});
            if (exp_rv) check_val("resp_pd", {30'h0, csb_resp_pd}, {30'h0, exp_pd});
            check_val("producer", {63'h0, producer}, {63'h0, m_prod});
            check_val("consumer", {63'h0, consumer}, {63'h0, m_cons});
            check_val("op_en", {62'h0, d1_op_en, d0_op_en}, {62'h0, m_op[1], m_op[0]});
            check_val("prdy", {63'h0, csb_req_prdy}, 64'h1);
            // Slave-bus outputs for the request in its access cycle
            if (p_vld) begin
                e_off  = {p_addr, 2'b00};
                e_dual = (e_off >= 12'h008);
                e_blk  = is_blocked(e_off, p_write);
                check_val("reg_offset", {52'h0, reg_offset}, {52'h0, e_off});
                check_val("reg_wr_data", {32'h0, reg_wr_data}, {32'h0, p_wdat});
                check_val("wr_en", {62'h0, d1_reg_wr_en, d0_reg_wr_en},
                          {62'h0, p_write && e_dual && !e_blk && m_prod,
                                  p_write && e_dual && !e_blk && !m_prod});
            end else begin
                check_val("idle_reg_offset", {52'h0, reg_offset}, 64'h0);
                check_val("idle_wr_en", {62'h0, d1_reg_wr_en, d0_reg_wr_en}, 64'h0);
            end
            // New stimulus
            csb_req_pvld = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 9);
            csb_req_addr = {$urandom_range(0, 4095), (r < 3) ? r[9:0] : 10'($urandom_range(3, 15))};
            csb_req_wdat = $urandom;
            csb_req_write = $urandom_range(0, 1);
            csb_req_nposted = $urandom_range(0, 1);
            done_now = ($urandom_range(0, 3) == 0);
            dp2reg_done = done_now;
            @(posedge autosa_core_clk);
            model_step(done_now);
            @(negedge autosa_core_clk);
        end

        // Reset with a read in flight: nothing may come back
        csb_req_pvld = 1'b1; csb_req_write = 1'b0; csb_req_addr = 22'h000001; dp2reg_done = 1'b0;
        @(negedge autosa_core_clk);
        csb_req_pvld = 1'b0;
        autosa_core_rstn = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge autosa_core_clk);
        autosa_core_rstn = 1'b1;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(negedge autosa_core_clk);
            check_val("post_rst_no_resp", {63'h0, csb_resp_valid}, 64'h0);
        end
        check_val("post_rst_prdy", {63'h0, csb_req_prdy}, 64'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
